time_mgr: RTL

// Receiving end of the PCParser -> TimeMgr control interface (reset_time, unit_len,
// PC_time_elapsed). Divides clk into time units of unit_len cycles, keeps the

---
 rtl/time_mgr.sv | 60 ++++++
 1 files changed

// File: rtl/time_mgr.sv
// time_mgr: splits clk into unit_len-cycle time units, counts elapsed units, stalls while PC is ahead, and sends one heartbeat per unit
module time_mgr #(
  parameter int Nunit = 16,
  parameter int Ntime = 40
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             reset_time,
  input  logic [Nunit-1:0] unit_len,
  input  logic [Ntime-1:0] PC_time_elapsed,
  output logic [Ntime-1:0] time_elapsed,
  output logic             unit_pulse,
  output logic             stall_dn,
  output logic [Ntime-1:0] HB_up_data,
  output logic             HB_up_v,
  input  logic             HB_up_a,
  output logic             HB_overrun
);
  logic [Nunit-1:0] clk_ct;
  logic             rollover;
  logic             xfer;
  assign rollover = !reset_time && unit_len != '0 && clk_ct >= unit_len - Nunit'(1);
  assign xfer     = HB_up_v && HB_up_a;
  assign stall_dn = PC_time_elapsed > time_elapsed;
  // cycle counter within a unit and the elapsed-unit count; a zero unit_len freezes both
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_ct       <= '0;
      time_elapsed <= '0;
      unit_pulse   <= 1'b0;
    end else if (reset_time) begin
      clk_ct       <= '0;
      time_elapsed <= '0;
      unit_pulse   <= 1'b0;
    end else if (rollover) begin
      clk_ct       <= '0;
      time_elapsed <= time_elapsed + Ntime'(1);
      unit_pulse   <= 1'b1;
    end else begin
      clk_ct       <= unit_len == '0 ? clk_ct : clk_ct + Nunit'(1);
      unit_pulse   <= 1'b0;
    end
  end
  // one-entry heartbeat buffer; an in-flight heartbeat survives reset_time, overrun is sticky until reset_time
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      HB_up_data <= '0;
      HB_up_v    <= 1'b0;
      HB_overrun <= 1'b0;
    end else begin
      if (rollover && (!HB_up_v || xfer)) begin
        HB_up_data <= time_elapsed + Ntime'(1);
        HB_up_v    <= 1'b1;
      end else if (xfer) begin
        HB_up_v    <= 1'b0;
      end
      HB_overrun <= !reset_time && (HB_overrun || (rollover && HB_up_v && !xfer));
    end
  end
endmodule
